// File: rtl/xaui_sup_pkg.sv
// Shared definitions for the XAUI receive-link supervisor: state encoding,
// state width and the counter-width helper used to size the timers.
package xaui_sup_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_LOOK  = 3'd0,
        ST_RESET = 3'd1,
        ST_WAIT  = 3'd2,
        ST_UP    = 3'd3,
        ST_FAULT = 3'd4
    } sup_state_e;

    // Bits needed to hold values 0..max_val; never less than one bit so that
    // a zero maximum still gives a legal vector width.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/xaui_sup_timer.sv
// Loadable down-counter with a done flag. Loading V makes done rise after
// V enabled cycles, so a phase that exits on done lasts V+1 cycles.
module xaui_sup_timer #(
    parameter int W = 4
) (
    input  logic         mgt_clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         done
);

    logic [W-1:0] count_reg;

    // Clear wins over load; decrement stops at zero.
    always_ff @(posedge mgt_clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/xaui_link_supervisor.sv
// Receive-link supervisor: watches lane sync, PLL lock and alignment, and
// drives stretched per-lane receive resets followed by a settle wait. The
// number of consecutive attempts is bounded, after which it latches FAULT.
module xaui_link_supervisor
    import xaui_sup_pkg::*;
#(
    parameter int N_LANES        = 4,
    parameter int WAIT_CYCLES    = 1 << 24,
    parameter int STRETCH_CYCLES = 15,
    parameter int MAX_RETRIES    = 15,
    parameter int PER_LANE_RESET = 1,
    parameter int CNT_W          = 16
) (
    input  logic               mgt_clk,
    input  logic               reset_n,
    input  logic               link_clear,
    input  logic [N_LANES-1:0] lane_sync,
    input  logic [N_LANES-1:0] rx_lock,
    input  logic               align_ok,
    output logic [N_LANES-1:0] mgt_rx_reset,
    output logic               link_up,
    output logic               fault,
    output logic [CNT_W-1:0]   retry_count,
    output logic [STATE_W-1:0] sup_state
);

    localparam int STR_W    = cnt_width(STRETCH_CYCLES);
    localparam int WAIT_W   = cnt_width(WAIT_CYCLES);
    localparam int CONSEC_W = cnt_width(MAX_RETRIES);

    // Timers are loaded with N-1 because the phase also spends the cycle
    // in which done is seen.
    localparam logic [STR_W-1:0]    STR_LOAD   = STR_W'(STRETCH_CYCLES - 1);
    localparam logic [WAIT_W-1:0]   WAIT_LOAD  = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_RETRIES);

    sup_state_e          state_reg, state_next;
    logic [N_LANES-1:0]  mask_reg, mask_next;
    logic [CONSEC_W-1:0] consec_reg, consec_next;
    logic [CNT_W-1:0]    retry_reg, retry_next;
    logic [N_LANES-1:0]  rx_reset_reg;
    logic                link_up_reg;
    logic                fault_reg;

    logic [N_LANES-1:0]  lane_bad;
    logic [N_LANES-1:0]  fail_mask;
    logic                good;
    logic                str_load, wait_load;
    logic                str_done, wait_done;

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign lane_bad[gi] = ~(lane_sync[gi] & rx_lock[gi]);
        end
    endgenerate

    assign good = (&lane_sync) & (&rx_lock) & align_ok;

    // An alignment-only failure has no culprit lane, so every lane is reset.
    assign fail_mask = ((PER_LANE_RESET == 0) || (lane_bad == '0)) ? '1 : lane_bad;

    xaui_sup_timer #(.W(STR_W)) u_stretch_timer (
        .mgt_clk    (mgt_clk),
        .reset_n    (reset_n),
        .clear      (link_clear),
        .load       (str_load),
        .load_value (STR_LOAD),
        .enable     (state_reg == ST_RESET),
        .done       (str_done)
    );

    xaui_sup_timer #(.W(WAIT_W)) u_wait_timer (
        .mgt_clk    (mgt_clk),
        .reset_n    (reset_n),
        .clear      (link_clear),
        .load       (wait_load),
        .load_value (WAIT_LOAD),
        .enable     (state_reg == ST_WAIT),
        .done       (wait_done)
    );

    // Next-state, mask capture and telemetry updates; link_clear overrides all.
    always_comb begin
        state_next  = state_reg;
        mask_next   = mask_reg;
        consec_next = consec_reg;
        retry_next  = retry_reg;
        str_load    = 1'b0;
        wait_load   = 1'b0;
        if (link_clear) begin
            state_next  = ST_LOOK;
            mask_next   = '0;
            consec_next = '0;
            retry_next  = '0;
        end else begin
            case (state_reg)
                ST_LOOK: begin
                    if (good) begin
                        state_next  = ST_UP;
                        consec_next = '0;
                    end else if ((MAX_RETRIES != 0) && (consec_reg == CONSEC_MAX)) begin
                        state_next = ST_FAULT;
                    end else begin
                        state_next = ST_RESET;
                        mask_next  = fail_mask;
                        str_load   = 1'b1;
                        if (consec_reg != CONSEC_MAX) consec_next = consec_reg + 1'b1;
                        if (retry_reg != '1)          retry_next  = retry_reg + 1'b1;
                    end
                end
                ST_RESET: begin
                    if (str_done) begin
                        state_next = ST_WAIT;
                        wait_load  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_done) state_next = ST_LOOK;
                end
                ST_UP: begin
                    if (!good) state_next = ST_LOOK;
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_LOOK;
                end
            endcase
        end
    end

    // State, telemetry and outputs; outputs are decoded from the next state so
    // they are registered and track the state register exactly.
    always_ff @(posedge mgt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_LOOK;
            mask_reg     <= '0;
            consec_reg   <= '0;
            retry_reg    <= '0;
            rx_reset_reg <= '0;
            link_up_reg  <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mask_reg     <= mask_next;
            consec_reg   <= consec_next;
            retry_reg    <= retry_next;
            rx_reset_reg <= (state_next == ST_RESET) ? mask_next : '0;
            link_up_reg  <= (state_next == ST_UP);
            fault_reg    <= (state_next == ST_FAULT);
        end
    end

    assign mgt_rx_reset = rx_reset_reg;
    assign link_up      = link_up_reg;
    assign fault        = fault_reg;
    assign retry_count  = retry_reg;
    assign sup_state    = state_reg;

endmodule
